dbus_ctrl: RTL and testbench

DBUS_CTRL -- requirements
Module: dbus_ctrl

---
 rtl/dbus_ctrl_if.sv | 42 ++++
 rtl/dbus_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dbus_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_ctrl_if.sv
// Pipeline-side request/response and data-bus signals of the dbus_ctrl load/store unit.
// master: the controller view; slave: the pipeline plus bus-slave environment view.
interface dbus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              addr_err;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [BE_W-1:0]   bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  bus_ack, bus_rdata,
        output stall, resp_valid, resp_rdata, addr_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output bus_ack, bus_rdata,
        input  stall, resp_valid, resp_rdata, addr_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: single-outstanding load/store unit bridging the pipeline to an acked data bus.
// Define DBUS_CTRL_ALIGN_CHECK_EN to trap misaligned and illegal-size requests via addr_err.
module dbus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    dbus_ctrl_if.master dbus,
    output logic [1:0]  dbg_state
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Request decode (IDLE-cycle view of the pipeline inputs).
    logic [1:0]        size_eff;
    int                acc_bytes;
    logic [OFF_W-1:0]  keep_mask;
    logic [OFF_W-1:0]  req_off;
    logic [BE_W-1:0]   size_mask;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata_rep;
    logic              legal;

    always_comb begin
        size_eff = dbus.req_size;
        if (DATA_W == 32 && dbus.req_size == 2'b11) begin
            size_eff = 2'b10;
        end
        acc_bytes = 1 << size_eff;
        // Offset bits below the access size are forced to zero.
        for (int i = 0; i < OFF_W; i++) begin
            keep_mask[i] = ((1 << i) >= acc_bytes);
        end
        req_off = dbus.req_addr[OFF_W-1:0] & keep_mask;
        for (int i = 0; i < BE_W; i++) begin
            size_mask[i] = (i < acc_bytes);
        end
        req_be = size_mask << req_off;
        case (size_eff)
            2'b00:   req_wdata_rep = {BE_W{dbus.req_wdata[7:0]}};
            2'b01:   req_wdata_rep = {(BE_W / 2){dbus.req_wdata[15:0]}};
            2'b10:   req_wdata_rep = {(DATA_W / 32){dbus.req_wdata[31:0]}};
            default: req_wdata_rep = dbus.req_wdata;
        endcase
`ifdef DBUS_CTRL_ALIGN_CHECK_EN
        legal = ((dbus.req_addr[OFF_W-1:0] & ~keep_mask) == '0) &&
                !(DATA_W == 32 && dbus.req_size == 2'b11);
`else
        legal = 1'b1;
`endif
    end

    // Load extraction: lane-shift, then sign/zero extend from the access width.
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_mask;
    logic [DATA_W-1:0] rd_ext;
    logic              rd_sign;
    int                rd_bits;

    always_comb begin
        rd_shift = dbus.bus_rdata >> {off_q, 3'b000};
        rd_bits  = 8 << size_q;
        for (int i = 0; i < DATA_W; i++) begin
            rd_mask[i] = (i < rd_bits);
        end
        case (size_q)
            2'b00:   rd_sign = rd_shift[7];
            2'b01:   rd_sign = rd_shift[15];
            default: rd_sign = rd_shift[31];
        endcase
        if (signed_q && rd_sign) begin
            rd_ext = rd_shift | ~rd_mask;
        end else begin
            rd_ext = rd_shift & rd_mask;
        end
    end

    // Handshake: a request is taken on the edge where the FSM is IDLE, req_valid is 1 and the
    // request is legal; stall holds the pipeline from that cycle until the DONE cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (dbus.req_valid && legal) begin
                    addr_d   = {dbus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    we_d     = dbus.req_we;
                    be_d     = req_be;
                    wdata_d  = req_wdata_rep;
                    size_d   = size_eff;
                    signed_d = dbus.req_signed;
                    off_d    = req_off;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dbus.bus_ack) begin
                    rdata_d = we_q ? '0 : rd_ext;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
        end
    end

    logic in_idle;
    logic in_busy;
    logic in_done;

    // Outputs are gated by rst so they read zero while reset is held, not only after it.
    assign in_idle = !rst && (state_q == S_IDLE);
    assign in_busy = !rst && (state_q == S_BUSY);
    assign in_done = !rst && (state_q == S_DONE);

    assign dbus.stall      = (in_idle && dbus.req_valid && legal) || in_busy;
    assign dbus.resp_valid = in_done;
    assign dbus.resp_rdata = rst ? '0 : rdata_q;
`ifdef DBUS_CTRL_ALIGN_CHECK_EN
    assign dbus.addr_err   = in_idle && dbus.req_valid && !legal;
`else
    assign dbus.addr_err   = 1'b0;
`endif
    assign dbus.bus_req    = in_busy;
    assign dbus.bus_we     = in_busy && we_q;
    assign dbus.bus_addr   = in_busy ? addr_q : '0;
    assign dbus.bus_be     = in_busy ? be_q : '0;
    assign dbus.bus_wdata  = in_busy ? wdata_q : '0;

    assign dbg_state = state_q;
endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl: a 32-bit and a 64-bit instance driven with directed and
// random loads/stores, checked against an arithmetic reference model.
module tb_dbus_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg32;
    logic [1:0] dbg64;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];

    logic [31:0] last_addr;
    logic [7:0]  last_be;
    logic [63:0] last_wdata;
    logic        last_we;
    logic        last_err;
    logic [63:0] last_rdata;
    int          last_lat;
    logic [7:0]  last64_be;
    logic [63:0] last64_rdata;

    dbus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
    dbus_ctrl_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

    dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .dbus      (b32.master),
        .dbg_state (dbg32)
    );

    dbus_ctrl #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .dbus      (b64.master),
        .dbg_state (dbg64)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic straight from the access rules.
    function automatic void ref_model(input int dw, input logic [1:0] size, input logic sgn,
                                      input logic [31:0] addr, input logic [63:0] wdata,
                                      input logic [63:0] rdata, output bit legal,
                                      output logic [31:0] e_addr, output logic [7:0] e_be,
                                      output logic [63:0] e_wdata, output logic [63:0] e_rdata);
        int lanes;
        int n;
        int off;
        longint unsigned m;
        longint unsigned v;
        longint unsigned rep;
        lanes = dw / 8;
        n     = 1 << size;
        legal = 1'b1;
`ifdef DBUS_CTRL_ALIGN_CHECK_EN
        if (n > lanes || (addr % n) != 0) legal = 1'b0;
`endif
        if (n > lanes) n = lanes;
        off    = int'(addr % lanes);
        off    = off - (off % n);
        e_addr = addr - (addr % lanes);
        e_be   = 8'(((1 << n) - 1) << off);
        m      = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v      = wdata & m;
        rep    = 0;
        for (int k = 0; k < lanes / n; k++) rep |= v << (8 * n * k);
        e_wdata = rep;
        v = (rdata >> (8 * off)) & m;
        if (sgn && v[8*n-1]) v |= ~m;
        if (dw == 32) v &= 64'h0000_0000_FFFF_FFFF;
        e_rdata = v;
    endfunction

    // Driver for the 32-bit instance: entered and left just after a rising edge, FSM in IDLE.
    task automatic txn32(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_dly);
        bit          legal;
        bit          seen;
        int          cyc;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        ref_model(32, size, sgn, addr, {32'd0, wdata}, {32'd0, rdata},
                  legal, e_addr, e_be, e_wdata, e_rdata);
        if (we) e_rdata = '0;
        b32.req_valid  = 1'b1;
        b32.req_we     = we;
        b32.req_size   = size;
        b32.req_signed = sgn;
        b32.req_addr   = addr;
        b32.req_wdata  = wdata;
        b32.bus_ack    = 1'b0;
        @(negedge clk);
        last_err = b32.addr_err;
        if (!legal) begin
            check("err_pulse", b32.addr_err, 1);
            check("err_stall", b32.stall, 0);
            check("err_busreq", b32.bus_req, 0);
            @(posedge clk); #1;
            b32.req_valid = 1'b0;
            @(negedge clk);
            check("err_once", b32.addr_err, 0);
            check("err_idle", dbg32, 0);
            check("err_nobus", b32.bus_req, 0);
            @(posedge clk); #1;
            return;
        end
        check("acc_stall", b32.stall, 1);
        check("acc_err", b32.addr_err, 0);
        check("acc_nobus", b32.bus_req, 0);
        exp_q.push_back(e_rdata);
        @(posedge clk); #1;
        seen = 0;
        for (cyc = 1; cyc <= ack_dly + 12; cyc++) begin
            // Garbage request fields while busy must be ignored.
            b32.req_valid  = (cyc <= ack_dly + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            b32.req_we     = 1'($urandom_range(0, 1));
            b32.req_size   = 2'($urandom_range(0, 3));
            b32.req_signed = 1'($urandom_range(0, 1));
            b32.req_addr   = $urandom;
            b32.req_wdata  = $urandom;
            if (cyc == ack_dly + 1) begin
                b32.bus_ack   = 1'b1;
                b32.bus_rdata = rdata;
            end else begin
                b32.bus_ack   = (cyc > ack_dly + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                b32.bus_rdata = $urandom;
            end
            @(negedge clk);
            if (b32.resp_valid) begin
                seen = 1;
                break;
            end
            if (cyc == 1) begin
                last_addr  = b32.bus_addr;
                last_be    = 8'(b32.bus_be);
                last_wdata = 64'(b32.bus_wdata);
                last_we    = b32.bus_we;
            end
            check("busy_req", b32.bus_req, 1);
            check("busy_stall", b32.stall, 1);
            check("busy_err", b32.addr_err, 0);
            check("busy_addr", b32.bus_addr, e_addr);
            check("busy_be", b32.bus_be, e_be);
            check("busy_we", b32.bus_we, we);
            if (we) check("busy_wdata", b32.bus_wdata, e_wdata);
            @(posedge clk); #1;
        end
        last_lat = cyc;
        check("resp_seen", seen, 1);
        check("latency", cyc, ack_dly + 2);
        if (seen) begin
            last_rdata = 64'(b32.resp_rdata);
            check("resp_q_nonempty", exp_q.size(), 1);
            if (exp_q.size() > 0) check("resp_rdata", b32.resp_rdata, exp_q.pop_front());
            check("done_stall", b32.stall, 0);
            check("done_nobus", b32.bus_req, 0);
            @(posedge clk); #1;
            b32.bus_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("resp_once", b32.resp_valid, 0);
            check("idle_nobus", b32.bus_req, 0);
            check("idle_state", dbg32, 0);
            @(posedge clk); #1;
            b32.bus_ack = 1'b0;
        end else begin
            exp_q.delete();
        end
    endtask

    // Driver for the 64-bit instance, ack in the first BUSY cycle.
    task automatic txn64(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata);
        bit          legal;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        ref_model(64, size, sgn, addr, wdata, rdata, legal, e_addr, e_be, e_wdata, e_rdata);
        if (we) e_rdata = '0;
        b64.req_valid  = 1'b1;
        b64.req_we     = we;
        b64.req_size   = size;
        b64.req_signed = sgn;
        b64.req_addr   = addr;
        b64.req_wdata  = wdata;
        b64.bus_ack    = 1'b0;
        @(negedge clk);
        if (!legal) begin
            check("e64_err", b64.addr_err, 1);
            check("e64_stall", b64.stall, 0);
            @(posedge clk); #1;
            b64.req_valid = 1'b0;
            return;
        end
        check("a64_stall", b64.stall, 1);
        @(posedge clk); #1;
        b64.req_valid = 1'b0;
        b64.bus_ack   = 1'b1;
        b64.bus_rdata = rdata;
        @(negedge clk);
        last64_be = b64.bus_be;
        check("b64_req", b64.bus_req, 1);
        check("b64_addr", b64.bus_addr, e_addr);
        check("b64_be", b64.bus_be, e_be);
        check("b64_we", b64.bus_we, we);
        if (we) check("b64_wdata", b64.bus_wdata, e_wdata);
        @(posedge clk); #1;
        b64.bus_ack = 1'b0;
        @(negedge clk);
        last64_rdata = b64.resp_rdata;
        check("r64_valid", b64.resp_valid, 1);
        check("r64_rdata", b64.resp_rdata, e_rdata);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero32(input string tag);
        check({tag, "_stall"}, b32.stall, 0);
        check({tag, "_resp_valid"}, b32.resp_valid, 0);
        check({tag, "_addr_err"}, b32.addr_err, 0);
        check({tag, "_bus_req"}, b32.bus_req, 0);
        check({tag, "_bus_we"}, b32.bus_we, 0);
        check({tag, "_bus_be"}, b32.bus_be, 0);
        check({tag, "_bus_addr"}, b32.bus_addr, 0);
        check({tag, "_bus_wdata"}, b32.bus_wdata, 0);
        check({tag, "_resp_rdata"}, b32.resp_rdata, 0);
    endtask

    initial begin
        rst            = 1'b1;
        b32.req_valid  = 1'b1;
        b32.req_we     = 1'b0;
        b32.req_size   = 2'b10;
        b32.req_signed = 1'b0;
        b32.req_addr   = 32'h100;
        b32.req_wdata  = '0;
        b32.bus_ack    = 1'b0;
        b32.bus_rdata  = '0;
        b64.req_valid  = 1'b0;
        b64.req_we     = 1'b0;
        b64.req_size   = 2'b00;
        b64.req_signed = 1'b0;
        b64.req_addr   = '0;
        b64.req_wdata  = '0;
        b64.bus_ack    = 1'b0;
        b64.bus_rdata  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero32("in_reset");
        check("in_reset_state", dbg32, 0);
        b32.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero32("post_reset");
        check("post_reset_b64_req", b64.bus_req, 0);
        @(posedge clk); #1;

        // Signed byte load from the top lane.
        txn32(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_FFFF, 0);
        check("r37_rdata", last_rdata, 64'hFFFF_FF80);
        check("r37_be", last_be, 8'b1000);
        check("r37_lat", last_lat, 2);

        // Half store at offset 2.
        txn32(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_BEEF, $urandom, 0);
        check("r38_addr", last_addr, 32'h2000);
        check("r38_be", last_be, 8'b1100);
        check("r38_wdata", last_wdata, 64'hBEEF_BEEF);
        check("r38_we", last_we, 1);

        // Word load with the ack withheld for five BUSY cycles.
        txn32(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 5);
        check("r39_lat", last_lat, 7);
        check("r39_rdata", last_rdata, 64'hCAFE_F00D);

        // Misaligned word load.
        txn32(1'b0, 2'b10, 1'b0, 32'h3002, 32'h0, 32'h1234_5678, 0);
`ifdef DBUS_CTRL_ALIGN_CHECK_EN
        check("r40_err", last_err, 1);
`else
        check("r40_err", last_err, 0);
        check("r40_addr", last_addr, 32'h3000);
`endif

        // Randomized traffic on the 32-bit instance.
        for (int t = 0; t < 60; t++) begin
            txn32(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom, $urandom_range(0, 4));
        end

        // Ensure a non-zero captured load result before the abort test.
        txn32(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'hDEAD_BEEF, 0);

        // Reset in the second BUSY cycle, then a stray ack.
        b32.req_valid  = 1'b1;
        b32.req_we     = 1'b1;
        b32.req_size   = 2'b10;
        b32.req_signed = 1'b0;
        b32.req_addr   = 32'h600;
        b32.req_wdata  = 32'h5555_AAAA;
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero32("abort_rst");
        @(posedge clk); #1;
        rst           = 1'b0;
        b32.bus_ack   = 1'b1;
        b32.bus_rdata = $urandom;
        @(negedge clk);
        check_all_zero32("abort_after");
        check("abort_state", dbg32, 0);
        @(posedge clk); #1;
        b32.bus_ack = 1'b0;
        @(negedge clk);
        check("abort_no_resp", b32.resp_valid, 0);
        check("abort_state2", dbg32, 0);
        @(posedge clk); #1;

        // 64-bit instance: full-width dword load, then random traffic.
        txn64(1'b0, 2'b11, 1'b0, 32'h8, 64'h0, 64'h8000_0000_0000_0001);
        check("r42_be", last64_be, 8'hFF);
        check("r42_rdata", last64_rdata, 64'h8000_0000_0000_0001);
        txn64(1'b0, 2'b10, 1'b1, 32'h14, 64'h0, 64'h9000_0000_1234_5678);
        check("w64_sext", last64_rdata, 64'hFFFF_FFFF_9000_0000);
        for (int t = 0; t < 24; t++) begin
            txn64(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
